// File: rtl/punc_control_fsm_if.sv
// Control interface between the PUnC controller and its datapath.
// The controller is the master: it observes ir_out/nzp_match and drives every strobe and select.
interface punc_control_fsm_if;
  logic [15:0] ir_out;
  logic        nzp_match;

  logic        pc_ld;
  logic        pc_clr;
  logic        pc_inc;
  logic [1:0]  pc_sel;
  logic        ir_ld;
  logic        ir_clr;
  logic        mem_rd;
  logic        mem_wr;
  logic [1:0]  mem_r_addr_sel;
  logic [1:0]  mem_w_addr_sel;
  logic [1:0]  rf_w_data_sel;
  logic        rf_w_addr_sel;
  logic        rf_w_wr;
  logic        rf_rp_addr_sel;
  logic        rf_rp_rd;
  logic        rf_rq_rd;
  logic        temp_ld;
  logic        nzp_ld;
  logic        nzp_clr;
  logic [1:0]  alu_sel;
  logic        alu_first_val_sel;
  logic        halted;

  modport master (
    input  ir_out, nzp_match,
    output pc_ld, pc_clr, pc_inc, pc_sel, ir_ld, ir_clr, mem_rd, mem_wr,
           mem_r_addr_sel, mem_w_addr_sel, rf_w_data_sel, rf_w_addr_sel, rf_w_wr,
           rf_rp_addr_sel, rf_rp_rd, rf_rq_rd, temp_ld, nzp_ld, nzp_clr,
           alu_sel, alu_first_val_sel, halted
  );

  modport slave (
    output ir_out, nzp_match,
    input  pc_ld, pc_clr, pc_inc, pc_sel, ir_ld, ir_clr, mem_rd, mem_wr,
           mem_r_addr_sel, mem_w_addr_sel, rf_w_data_sel, rf_w_addr_sel, rf_w_wr,
           rf_rp_addr_sel, rf_rp_rd, rf_rq_rd, temp_ld, nzp_ld, nzp_clr,
           alu_sel, alu_first_val_sel, halted
  );
endinterface

// File: rtl/punc_control_fsm.sv
// Multicycle sequencer for the PUnC LC3 core.
//
//   state  | meaning
//   INIT   | clear PC, IR and condition codes
//   FETCH  | IR <= mem[PC], PC <= PC + 1
//   DECODE | settle IR; HALT_OP goes to HALT
//   EXEC   | perform the instruction (first access for LDI/STI)
//   EXEC2  | second memory access of LDI/STI through temp
//   HALT   | halted, no strobes until reset
module punc_control_fsm #(
  parameter logic [3:0] HALT_OP = 4'b1111,
  parameter bit         LEA_CC  = 1'b0
) (
  input logic                 clk,
  input logic                 rst,
  punc_control_fsm_if.master  ctl
);

  typedef enum logic [2:0] {
    INIT   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    EXEC2  = 3'd4,
    HALT   = 3'd5
  } state_t;

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_LDI  = 4'b1010;
  localparam logic [3:0] OP_STI  = 4'b1011;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_LEA  = 4'b1110;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] opcode;

  assign opcode = ctl.ir_out[15:12];

  // State register; reset forces INIT immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= INIT;
    else      state <= state_nxt;
  end

  // Instruction sequencing.
  always_comb begin
    state_nxt = state;
    case (state)
      INIT:    state_nxt = FETCH;
      FETCH:   state_nxt = DECODE;
      DECODE:  state_nxt = (opcode == HALT_OP) ? HALT : EXEC;
      EXEC:    state_nxt = (opcode == OP_LDI || opcode == OP_STI) ? EXEC2 : FETCH;
      EXEC2:   state_nxt = FETCH;
      HALT:    state_nxt = HALT;
      default: state_nxt = INIT;
    endcase
  end

  // Datapath controls from state and IR; everything is forced low while reset is held.
  always_comb begin
    ctl.pc_ld             = 1'b0;
    ctl.pc_clr            = 1'b0;
    ctl.pc_inc            = 1'b0;
    ctl.pc_sel            = 2'd0;
    ctl.ir_ld             = 1'b0;
    ctl.ir_clr            = 1'b0;
    ctl.mem_rd            = 1'b0;
    ctl.mem_wr            = 1'b0;
    ctl.mem_r_addr_sel    = 2'd0;
    ctl.mem_w_addr_sel    = 2'd0;
    ctl.rf_w_data_sel     = 2'd0;
    ctl.rf_w_addr_sel     = 1'b0;
    ctl.rf_w_wr           = 1'b0;
    ctl.rf_rp_addr_sel    = 1'b0;
    ctl.rf_rp_rd          = 1'b0;
    ctl.rf_rq_rd          = 1'b0;
    ctl.temp_ld           = 1'b0;
    ctl.nzp_ld            = 1'b0;
    ctl.nzp_clr           = 1'b0;
    ctl.alu_sel           = 2'd0;
    ctl.alu_first_val_sel = 1'b0;
    ctl.halted            = 1'b0;
    if (rst) begin
      case (state)
        INIT: begin
          ctl.pc_clr  = 1'b1;
          ctl.ir_clr  = 1'b1;
          ctl.nzp_clr = 1'b1;
        end
        FETCH: begin
          ctl.mem_rd         = 1'b1;
          ctl.mem_r_addr_sel = 2'd0;
          ctl.ir_ld          = 1'b1;
          ctl.pc_inc         = 1'b1;
        end
        EXEC: begin
          case (opcode)
            OP_ADD, OP_AND: begin
              ctl.rf_rp_rd          = 1'b1;
              ctl.rf_rq_rd          = 1'b1;
              ctl.alu_sel           = (opcode == OP_AND) ? 2'd1 : 2'd0;
              ctl.alu_first_val_sel = ctl.ir_out[5];
              ctl.rf_w_wr           = 1'b1;
              ctl.nzp_ld            = 1'b1;
            end
            OP_NOT: begin
              ctl.rf_rp_rd = 1'b1;
              ctl.alu_sel  = 2'd2;
              ctl.rf_w_wr  = 1'b1;
              ctl.nzp_ld   = 1'b1;
            end
            // nzp_match is already zero for an empty nzp field; the extra term keeps BR-never safe.
            OP_BR: begin
              ctl.pc_sel = 2'd0;
              ctl.pc_ld  = ctl.nzp_match && (ctl.ir_out[11:9] != 3'b000);
            end
            OP_JMP: begin
              ctl.rf_rp_rd = 1'b1;
              ctl.pc_sel   = 2'd2;
              ctl.pc_ld    = 1'b1;
            end
            // R7 write and PC load share the cycle, so JSRR R7 jumps through the old R7.
            OP_JSR: begin
              ctl.rf_w_wr       = 1'b1;
              ctl.rf_w_addr_sel = 1'b1;
              ctl.rf_w_data_sel = 2'd3;
              ctl.pc_ld         = 1'b1;
              ctl.pc_sel        = ctl.ir_out[11] ? 2'd1 : 2'd2;
              ctl.rf_rp_rd      = ~ctl.ir_out[11];
            end
            OP_LD, OP_LDR: begin
              ctl.mem_rd         = 1'b1;
              ctl.mem_r_addr_sel = (opcode == OP_LDR) ? 2'd2 : 2'd1;
              ctl.rf_rq_rd       = (opcode == OP_LDR);
              ctl.rf_w_wr        = 1'b1;
              ctl.rf_w_data_sel  = 2'd1;
              ctl.nzp_ld         = 1'b1;
            end
            OP_LEA: begin
              ctl.rf_w_wr       = 1'b1;
              ctl.rf_w_data_sel = 2'd2;
              ctl.nzp_ld        = LEA_CC;
            end
            OP_ST, OP_STR: begin
              ctl.rf_rp_rd       = 1'b1;
              ctl.rf_rp_addr_sel = 1'b1;
              ctl.rf_rq_rd       = (opcode == OP_STR);
              ctl.mem_wr         = 1'b1;
              ctl.mem_w_addr_sel = (opcode == OP_STR) ? 2'd2 : 2'd1;
            end
            OP_LDI, OP_STI: begin
              ctl.mem_rd         = 1'b1;
              ctl.mem_r_addr_sel = 2'd1;
              ctl.temp_ld        = 1'b1;
            end
            default: ;
          endcase
        end
        EXEC2: begin
          if (opcode == OP_LDI) begin
            ctl.mem_rd         = 1'b1;
            ctl.mem_r_addr_sel = 2'd3;
            ctl.rf_w_wr        = 1'b1;
            ctl.rf_w_data_sel  = 2'd1;
            ctl.nzp_ld         = 1'b1;
          end else begin
            ctl.rf_rp_rd       = 1'b1;
            ctl.rf_rp_addr_sel = 1'b1;
            ctl.mem_wr         = 1'b1;
            ctl.mem_w_addr_sel = 2'd3;
          end
        end
        HALT:    ctl.halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_punc_control_fsm.sv
// Directed bench: the controller drives a small behavioural datapath model, and both the
// per-cycle strobes and the resulting architectural state are compared to hand-computed values.
module tb_punc_control_fsm;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  punc_control_fsm_if ifc ();

  punc_control_fsm #(.HALT_OP(4'b1111), .LEA_CC(1'b0)) dut (
    .clk (clk),
    .rst (rst),
    .ctl (ifc.master)
  );

  // Datapath model state, written only by the main process.
  logic [15:0] mem [0:255];
  logic [15:0] rf  [0:7];
  logic [15:0] pc, ir, temp;
  logic [2:0]  nzp;

  assign ifc.ir_out    = ir;
  assign ifc.nzp_match = |(ir[11:9] & nzp);

  // Strobe vector bit positions.
  localparam logic [13:0] B_PC_LD   = 14'h2000;
  localparam logic [13:0] B_PC_CLR  = 14'h1000;
  localparam logic [13:0] B_PC_INC  = 14'h0800;
  localparam logic [13:0] B_IR_LD   = 14'h0400;
  localparam logic [13:0] B_IR_CLR  = 14'h0200;
  localparam logic [13:0] B_MEM_RD  = 14'h0100;
  localparam logic [13:0] B_MEM_WR  = 14'h0080;
  localparam logic [13:0] B_RF_WR   = 14'h0040;
  localparam logic [13:0] B_RP_RD   = 14'h0020;
  localparam logic [13:0] B_RQ_RD   = 14'h0010;
  localparam logic [13:0] B_TEMP_LD = 14'h0008;
  localparam logic [13:0] B_NZP_LD  = 14'h0004;
  localparam logic [13:0] B_NZP_CLR = 14'h0002;
  localparam logic [13:0] B_HALTED  = 14'h0001;

  localparam logic [13:0] E_INIT  = B_PC_CLR | B_IR_CLR | B_NZP_CLR;
  localparam logic [13:0] E_FETCH = B_MEM_RD | B_IR_LD | B_PC_INC;

  int total = 0;
  int bad   = 0;
  logic [13:0] snap;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [13:0] cur_strobes();
    return {ifc.pc_ld, ifc.pc_clr, ifc.pc_inc, ifc.ir_ld, ifc.ir_clr, ifc.mem_rd, ifc.mem_wr,
            ifc.rf_w_wr, ifc.rf_rp_rd, ifc.rf_rq_rd, ifc.temp_ld, ifc.nzp_ld, ifc.nzp_clr,
            ifc.halted};
  endfunction

  // One clock: sample controls at negedge, evaluate datapath, commit just after posedge.
  task automatic tick();
    logic [2:0]  rp_a, rq_a, w_a;
    logic [15:0] rp, rq, off9, off11, base6, r_addr, w_addr, rdata, b, alu, wdata, pc_tgt;
    logic [13:0] s;
    @(negedge clk);
    s      = cur_strobes();
    rp_a   = ifc.rf_rp_addr_sel ? ir[11:9] : ir[8:6];
    rq_a   = (ifc.mem_r_addr_sel == 2'd2 || ifc.mem_w_addr_sel == 2'd2) ? ir[8:6] : ir[2:0];
    rp     = ifc.rf_rp_rd ? rf[rp_a] : 16'h0;
    rq     = ifc.rf_rq_rd ? rf[rq_a] : 16'h0;
    off9   = pc + {{7{ir[8]}}, ir[8:0]};
    off11  = pc + {{5{ir[10]}}, ir[10:0]};
    base6  = rq + {{10{ir[5]}}, ir[5:0]};
    case (ifc.mem_r_addr_sel)
      2'd0: r_addr = pc;
      2'd1: r_addr = off9;
      2'd2: r_addr = base6;
      default: r_addr = temp;
    endcase
    case (ifc.mem_w_addr_sel)
      2'd1: w_addr = off9;
      2'd2: w_addr = base6;
      2'd3: w_addr = temp;
      default: w_addr = pc;
    endcase
    rdata = ifc.mem_rd ? mem[r_addr[7:0]] : 16'h0;
    b     = ifc.alu_first_val_sel ? {{11{ir[4]}}, ir[4:0]} : rq;
    case (ifc.alu_sel)
      2'd0: alu = rp + b;
      2'd1: alu = rp & b;
      2'd2: alu = ~rp;
      default: alu = rp;
    endcase
    case (ifc.rf_w_data_sel)
      2'd0: wdata = alu;
      2'd1: wdata = rdata;
      2'd2: wdata = off9;
      default: wdata = pc;
    endcase
    case (ifc.pc_sel)
      2'd0: pc_tgt = off9;
      2'd1: pc_tgt = off11;
      default: pc_tgt = rp;
    endcase
    w_a = ifc.rf_w_addr_sel ? 3'd7 : ir[11:9];
    @(posedge clk);
    #1;
    snap = s;
    if (s & B_PC_CLR)      pc = 16'h0;
    else if (s & B_PC_LD)  pc = pc_tgt;
    else if (s & B_PC_INC) pc = pc + 16'h1;
    if (s & B_IR_CLR)      ir = 16'h0;
    else if (s & B_IR_LD)  ir = rdata;
    if (s & B_TEMP_LD)     temp = rdata;
    if (s & B_RF_WR)       rf[w_a] = wdata;
    if (s & B_NZP_CLR)     nzp = 3'b000;
    else if (s & B_NZP_LD) nzp = wdata[15] ? 3'b100 : (wdata == 16'h0 ? 3'b010 : 3'b001);
    if (s & B_MEM_WR)      mem[w_addr[7:0]] = rp;
  endtask

  task automatic run_instr(input string tag, input logic [13:0] e_exec,
                           input logic [13:0] e_exec2, input bit two);
    tick(); chk({tag, "_fetch"},  {2'b0, snap}, {2'b0, E_FETCH});
    tick(); chk({tag, "_decode"}, {2'b0, snap}, 16'h0);
    tick(); chk({tag, "_exec"},   {2'b0, snap}, {2'b0, e_exec});
    if (two) begin
      tick(); chk({tag, "_exec2"}, {2'b0, snap}, {2'b0, e_exec2});
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0;
    for (int i = 0; i < 8; i++)   rf[i]  = 16'h0;
    pc = 16'h1234; ir = 16'h0; temp = 16'h0; nzp = 3'b000;

    mem[8'h00] = 16'h1261;  // ADD R1,R1,#1
    mem[8'h01] = 16'hD000;  // opcode 1101: NOP
    mem[8'h02] = 16'h09FD;  // BRn -3 -> x0000
    mem[8'h03] = 16'hA40C;  // LDI R2, ptr at x10
    mem[8'h04] = 16'hB40C;  // STI R2, ptr at x11
    mem[8'h05] = 16'h0000;  // BR never
    mem[8'h06] = 16'h41C0;  // JSRR R7
    mem[8'h10] = 16'h0020;
    mem[8'h11] = 16'h0030;
    mem[8'h20] = 16'h0007;
    mem[8'h40] = 16'hE605;  // LEA R3, x46
    mem[8'h41] = 16'hF025;  // HALT
    rf[1] = 16'hFFFE;
    rf[7] = 16'h0040;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_quiet", {2'b0, cur_strobes()}, 16'h0);
    @(posedge clk);
    #1 rst = 1'b1;

    tick(); chk("init", {2'b0, snap}, {2'b0, E_INIT});
    chk("init_pc", pc, 16'h0);

    run_instr("add1", B_RP_RD | B_RQ_RD | B_RF_WR | B_NZP_LD, 14'h0, 1'b0);
    chk("add1_r1", rf[1], 16'hFFFF);
    chk("add1_nzp", {13'h0, nzp}, 16'h4);
    run_instr("nop1", 14'h0, 14'h0, 1'b0);
    chk("nop1_pc", pc, 16'h2);
    run_instr("brn_taken", B_PC_LD, 14'h0, 1'b0);
    chk("brn_taken_pc", pc, 16'h0);
    run_instr("add2", B_RP_RD | B_RQ_RD | B_RF_WR | B_NZP_LD, 14'h0, 1'b0);
    chk("add2_r1", rf[1], 16'h0);
    chk("add2_nzp", {13'h0, nzp}, 16'h2);
    run_instr("nop2", 14'h0, 14'h0, 1'b0);
    run_instr("brn_not", 14'h0, 14'h0, 1'b0);
    chk("brn_not_pc", pc, 16'h3);
    run_instr("ldi", B_MEM_RD | B_TEMP_LD, B_MEM_RD | B_RF_WR | B_NZP_LD, 1'b1);
    chk("ldi_temp", temp, 16'h0020);
    chk("ldi_r2", rf[2], 16'h0007);
    chk("ldi_nzp", {13'h0, nzp}, 16'h1);
    run_instr("sti", B_MEM_RD | B_TEMP_LD, B_RP_RD | B_MEM_WR, 1'b1);
    chk("sti_mem", mem[8'h30], 16'h0007);
    run_instr("br_never", 14'h0, 14'h0, 1'b0);
    chk("br_never_pc", pc, 16'h6);
    run_instr("jsrr", B_RF_WR | B_PC_LD | B_RP_RD, 14'h0, 1'b0);
    chk("jsrr_pc", pc, 16'h0040);
    chk("jsrr_r7", rf[7], 16'h0007);
    run_instr("lea", B_RF_WR, 14'h0, 1'b0);
    chk("lea_r3", rf[3], 16'h0046);
    chk("lea_nzp", {13'h0, nzp}, 16'h1);

    tick(); chk("halt_fetch", {2'b0, snap}, {2'b0, E_FETCH});
    tick(); chk("halt_decode", {2'b0, snap}, 16'h0);
    for (int i = 0; i < 4; i++) begin
      tick(); chk("halted", {2'b0, snap}, {2'b0, B_HALTED});
    end
    chk("halt_pc", pc, 16'h0042);

    // Reset in the middle of STI's second cycle must suppress the store.
    mem[8'h00] = 16'hB40C;  // STI R2, ptr at x0D
    mem[8'h0D] = 16'h0050;
    @(posedge clk);
    #1 rst = 1'b0;
    #1 chk("rst_async_halt", {2'b0, cur_strobes()}, 16'h0);
    @(posedge clk);
    #1 rst = 1'b1;
    tick(); chk("init2", {2'b0, snap}, {2'b0, E_INIT});
    tick(); chk("sti_r_fetch", {2'b0, snap}, {2'b0, E_FETCH});
    tick(); chk("sti_r_decode", {2'b0, snap}, 16'h0);
    tick(); chk("sti_r_exec", {2'b0, snap}, {2'b0, B_MEM_RD | B_TEMP_LD});
    chk("sti_r_live", {2'b0, cur_strobes()}, {2'b0, B_RP_RD | B_MEM_WR});
    rst = 1'b0;
    #1 chk("sti_r_abort", {2'b0, cur_strobes()}, 16'h0);
    for (int i = 0; i < 3; i++) begin
      tick(); chk("sti_r_held", {2'b0, snap}, 16'h0);
    end
    chk("sti_r_mem", mem[8'h50], 16'h0);
    @(posedge clk);
    #1 rst = 1'b1;
    tick(); chk("init3", {2'b0, snap}, {2'b0, E_INIT});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
